// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (B).
// Registers the winning write, drops X31 writes, and forwards the in-flight write.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold,
    input  logic                  req_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    output logic                  gnt_a,
    input  logic                  req_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic                  gnt_b,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  drop,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  fwd_hit,
    output logic [DATA_WIDTH-1:0] fwd_data
);

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    localparam logic [ADDR_WIDTH-1:0] ZERO_REG = {ADDR_WIDTH{1'b1}};

    src_e                  last;
    logic                  any_gnt;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_zero;

    // Contested cycles go to whichever source was not granted last.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!reset && !hold) begin
            gnt_a = req_a && (!req_b || last == SRC_B);
            gnt_b = req_b && (!req_a || last == SRC_A);
        end
    end

    assign any_gnt = gnt_a || gnt_b;

    always_comb begin
        sel_addr = addr_a;
        sel_data = data_a;
        unique case (1'b1)
            gnt_a: begin
                sel_addr = addr_a;
                sel_data = data_a;
            end
            gnt_b: begin
                sel_addr = addr_b;
                sel_data = data_b;
            end
            default: ;
        endcase
    end

    assign sel_zero = sel_addr == ZERO_REG;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= SRC_B;
        end else if (any_gnt) begin
            last <= gnt_b ? SRC_B : SRC_A;
        end
    end

    // Address/data hold when idle; only the strobes clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            drop    <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= any_gnt && !sel_zero;
            drop  <= any_gnt && sel_zero;
            if (any_gnt) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

    assign fwd_hit  = wr_en && (wr_addr == rd_addr);
    assign fwd_data = wr_data;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table plus
// hand sequences for reset, alternation and asynchronous reset.
module tb_regfile_write_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;

    logic          clk;
    logic          reset;
    logic          hold;
    logic          req_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] data_a;
    logic          gnt_a;
    logic          req_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] data_b;
    logic          gnt_b;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          drop;
    logic [AW-1:0] rd_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_write_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .hold    (hold),
        .req_a   (req_a),
        .addr_a  (addr_a),
        .data_a  (data_a),
        .gnt_a   (gnt_a),
        .req_b   (req_b),
        .addr_b  (addr_b),
        .data_b  (data_b),
        .gnt_b   (gnt_b),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .drop    (drop),
        .rd_addr (rd_addr),
        .fwd_hit (fwd_hit),
        .fwd_data(fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          hold;
        logic          req_a;
        logic [AW-1:0] addr_a;
        logic [DW-1:0] data_a;
        logic          req_b;
        logic [AW-1:0] addr_b;
        logic [DW-1:0] data_b;
        logic [AW-1:0] rd_addr;
        logic          gnt_a;
        logic          gnt_b;
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic          drop;
        logic          fwd_hit;
    } vec_t;

    function automatic vec_t mk(
        int h, int ra, int aa, logic [DW-1:0] da,
        int rb, int ab, logic [DW-1:0] db, int rd,
        int ga, int gb, int we, int wa,
        logic [DW-1:0] wd, int dr, int fh
    );
        vec_t v;
        v.hold    = h != 0;
        v.req_a   = ra != 0;
        v.addr_a  = AW'(aa);
        v.data_a  = da;
        v.req_b   = rb != 0;
        v.addr_b  = AW'(ab);
        v.data_b  = db;
        v.rd_addr = AW'(rd);
        v.gnt_a   = ga != 0;
        v.gnt_b   = gb != 0;
        v.wr_en   = we != 0;
        v.wr_addr = AW'(wa);
        v.wr_data = wd;
        v.drop    = dr != 0;
        v.fwd_hit = fh != 0;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic en,
                              input logic [AW-1:0] wa,
                              input logic [DW-1:0] wd, input logic dr);
        check({tag, ".wr_en"}, DW'(wr_en), DW'(en));
        check({tag, ".wr_addr"}, DW'(wr_addr), DW'(wa));
        check({tag, ".wr_data"}, wr_data, wd);
        check({tag, ".drop"}, DW'(drop), DW'(dr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[16];

    initial begin
        vecs[0]  = mk(0,1,5,64'hDEAD,0,0,64'h0,5,   1,0,1,5,64'hDEAD,0,1);
        vecs[1]  = mk(0,1,1,64'h11,1,2,64'h22,0,    0,1,1,2,64'h22,0,0);
        vecs[2]  = mk(0,1,1,64'h11,1,2,64'h22,1,    1,0,1,1,64'h11,0,1);
        vecs[3]  = mk(0,1,1,64'h11,1,2,64'h22,1,    0,1,1,2,64'h22,0,0);
        vecs[4]  = mk(0,1,1,64'h11,1,2,64'h22,2,    1,0,1,1,64'h11,0,0);
        vecs[5]  = mk(0,0,0,64'h0,1,31,64'h1234,31, 0,1,0,31,64'h1234,1,0);
        vecs[6]  = mk(0,1,3,64'h33,1,4,64'h44,3,    1,0,1,3,64'h33,0,1);
        vecs[7]  = mk(0,0,0,64'h0,0,0,64'h0,3,      0,0,0,3,64'h33,0,0);
        vecs[8]  = mk(1,1,3,64'h33,1,4,64'h44,3,    0,0,0,3,64'h33,0,0);
        vecs[9]  = mk(1,1,3,64'h33,1,4,64'h44,3,    0,0,0,3,64'h33,0,0);
        vecs[10] = mk(0,1,3,64'h33,1,4,64'h44,4,    0,1,1,4,64'h44,0,1);
        vecs[11] = mk(0,1,7,64'h55,0,0,64'h0,7,     1,0,1,7,64'h55,0,1);
        vecs[12] = mk(0,1,7,64'h55,0,0,64'h0,8,     1,0,1,7,64'h55,0,0);
        vecs[13] = mk(0,1,9,64'h99,1,10,64'hAA,10,  0,1,1,10,64'hAA,0,1);
        vecs[14] = mk(0,1,31,64'h77,0,0,64'h0,31,   1,0,0,31,64'h77,1,0);
        vecs[15] = mk(0,1,1,64'h11,1,2,64'h22,2,    0,1,1,2,64'h22,0,1);

        // Reset with both requesters active: no grants, cleared outputs.
        reset   = 1'b1;
        hold    = 1'b0;
        req_a   = 1'b1;
        addr_a  = 5'd1;
        data_a  = 64'h11;
        req_b   = 1'b1;
        addr_b  = 5'd2;
        data_b  = 64'h22;
        rd_addr = 5'd0;
        #12;
        check("rst.gnt_a", DW'(gnt_a), DW'(1'b0));
        check("rst.gnt_b", DW'(gnt_b), DW'(1'b0));
        check_outs("rst", 1'b0, 5'd0, 64'h0, 1'b0);

        // Contested from reset: A, B, A, B.
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            check("alt.gnt_a", DW'(gnt_a), DW'((i % 2) == 0));
            check("alt.gnt_b", DW'(gnt_b), DW'((i % 2) == 1));
            @(posedge clk);
            #1;
            check_outs("alt", 1'b1, (i % 2 == 0) ? 5'd1 : 5'd2,
                       (i % 2 == 0) ? 64'h11 : 64'h22, 1'b0);
        end

        // Fresh reset, one idle cycle, then the vector table.
        @(negedge clk);
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            hold    = vecs[i].hold;
            req_a   = vecs[i].req_a;
            addr_a  = vecs[i].addr_a;
            data_a  = vecs[i].data_a;
            req_b   = vecs[i].req_b;
            addr_b  = vecs[i].addr_b;
            data_b  = vecs[i].data_b;
            rd_addr = vecs[i].rd_addr;
            #1;
            check($sformatf("v%0d.gnt_a", i), DW'(gnt_a), DW'(vecs[i].gnt_a));
            check($sformatf("v%0d.gnt_b", i), DW'(gnt_b), DW'(vecs[i].gnt_b));
            @(posedge clk);
            #1;
            check_outs($sformatf("v%0d", i), vecs[i].wr_en, vecs[i].wr_addr,
                       vecs[i].wr_data, vecs[i].drop);
            check($sformatf("v%0d.fwd_hit", i), DW'(fwd_hit),
                  DW'(vecs[i].fwd_hit));
            check($sformatf("v%0d.fwd_data", i), fwd_data, vecs[i].wr_data);
        end

        // Asynchronous reset mid-cycle while a write is in flight.
        @(negedge clk);
        hold    = 1'b0;
        req_a   = 1'b1;
        addr_a  = 5'd6;
        data_a  = 64'h66;
        req_b   = 1'b0;
        rd_addr = 5'd6;
        @(posedge clk);
        #1;
        check_outs("pre_arst", 1'b1, 5'd6, 64'h66, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_outs("arst", 1'b0, 5'd0, 64'h0, 1'b0);
        check("arst.gnt_a", DW'(gnt_a), DW'(1'b0));
        check("arst.fwd_hit", DW'(fwd_hit), DW'(1'b0));
        @(negedge clk);
        reset  = 1'b0;
        addr_a = 5'd1;
        data_a = 64'h11;
        req_b  = 1'b1;
        #1;
        check("post_arst.gnt_a", DW'(gnt_a), DW'(1'b1));
        check("post_arst.gnt_b", DW'(gnt_b), DW'(1'b0));
        @(posedge clk);
        #1;
        check_outs("post_arst", 1'b1, 5'd1, 64'h11, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
